montpro_serial: RTL and testbench



---
 rtl/montpro_serial_if.sv | 19 +
 rtl/montpro_serial.sv | 91 +++++++++
 tb/tb_montpro_serial.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/montpro_serial_if.sv
// Request/response bundle between a Montgomery-product sequencer (master) and
// the bit-serial engine (slave).
interface montpro_serial_if #(
    parameter int WID = 256
);
    // Master drives a/b/m and a one-cycle start. start is honoured only while
    // busy is low. The slave answers with a one-cycle vld; r is meaningful only
    // in that cycle and reads zero otherwise. There is no backpressure.
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [WID-1:0] m;
    logic           start;
    logic [WID-1:0] r;
    logic           vld;
    logic           busy;

    modport master (output a, b, m, start, input r, vld, busy);
    modport slave  (input a, b, m, start, output r, vld, busy);
endinterface

// File: rtl/montpro_serial.sv
// Radix-2 bit-serial Montgomery product r = a*b*2^-WID mod m with fixed
// WID+1 cycle latency, so paired instances started together finish together.
module montpro_serial #(
    parameter int             WID    = 256,
    parameter int             CNTWID = 8,
    parameter logic [WID-1:0] ZERO   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    montpro_serial_if.slave   mp,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOOP  = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t            state_q;
    logic [WID-1:0]    areg_q;
    logic [WID-1:0]    breg_q;
    logic [WID-1:0]    mreg_q;
    logic [WID+1:0]    s_q;
    logic [CNTWID-1:0] cnt_q;
    logic [WID-1:0]    r_q;
    logic              vld_q;

    logic [WID+1:0]    t_add_b;
    logic [WID+1:0]    t_add_m;
    logic [WID+1:0]    s_d;
    logic [WID+1:0]    s_minus_m;
    logic [WID-1:0]    r_d;
    logic              last_iter;

    // s < 2m and t < 4m, so WID+2 bits never overflow.
    always_comb begin
        t_add_b   = s_q + (areg_q[cnt_q] ? {2'b00, breg_q} : '0);
        t_add_m   = t_add_b + (t_add_b[0] ? {2'b00, mreg_q} : '0);
        s_d       = t_add_m >> 1;
        s_minus_m = s_q - {2'b00, mreg_q};
        r_d       = (s_q >= {2'b00, mreg_q}) ? s_minus_m[WID-1:0] : s_q[WID-1:0];
        last_iter = (cnt_q == CNTWID'(WID - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            areg_q  <= ZERO;
            breg_q  <= ZERO;
            mreg_q  <= ZERO;
            s_q     <= '0;
            cnt_q   <= '0;
            r_q     <= ZERO;
            vld_q   <= 1'b0;
        end else begin
            // Result port is a pulse: anything but FINAL returns it to zero.
            vld_q <= 1'b0;
            r_q   <= ZERO;
            case (state_q)
                S_IDLE: begin
                    if (mp.start) begin
                        areg_q  <= mp.a;
                        breg_q  <= mp.b;
                        mreg_q  <= mp.m;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    s_q   <= s_d;
                    cnt_q <= cnt_q + CNTWID'(1);
                    if (last_iter) begin
                        state_q <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_q     <= r_d;
                    vld_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mp.r        = r_q;
    assign mp.vld      = vld_q;
    assign mp.busy     = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_montpro_serial.sv
// Bench for montpro_serial: an 8-bit instance for corner sequences and a pair
// of 256-bit instances run in lockstep against a wide-arithmetic model.
module tb_montpro_serial;
    localparam int W8   = 8;
    localparam int W256 = 256;
    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   vld8_cnt;
    bit   scramble8;

    logic [1:0] dbg8, dbgp0, dbgp1;

    montpro_serial_if #(.WID(W8))   s8();
    montpro_serial_if #(.WID(W256)) p0();
    montpro_serial_if #(.WID(W256)) p1();

    montpro_serial #(.WID(W8), .CNTWID(3), .ZERO('0)) u8 (
        .clk(clk), .rst_n(rst_n), .mp(s8), .dbg_state_o(dbg8));
    montpro_serial #(.WID(W256), .CNTWID(8), .ZERO('0)) up0 (
        .clk(clk), .rst_n(rst_n), .mp(p0), .dbg_state_o(dbgp0));
    montpro_serial #(.WID(W256), .CNTWID(8), .ZERO('0)) up1 (
        .clk(clk), .rst_n(rst_n), .mp(p1), .dbg_state_o(dbgp1));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [W8-1:0]   exp8_q[$];
    logic [W256-1:0] expp0_q[$];
    logic [W256-1:0] expp1_q[$];

    task automatic check(input string name, input logic [259:0] got, input logic [259:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // a*b*2^-w mod m: reduce the product, then divide by two w times modulo odd m.
    function automatic logic [259:0] mont_ref(input logic [259:0] a, input logic [259:0] b,
                                              input logic [259:0] m, input int w);
        logic [519:0] p;
        logic [259:0] x;
        p = (520'(a) * 520'(b)) % 520'(m);
        x = p[259:0];
        for (int i = 0; i < w; i++) x = x[0] ? (x + m) >> 1 : x >> 1;
        return x;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin
        if (s8.vld) begin
            vld8_cnt++;
            total++;
            if (exp8_q.size() == 0) begin
                bad++;
                $display("FAIL r8_spurious_vld got=vld exp=no_vld");
            end else begin
                check("r8_result", 260'(s8.r), 260'(exp8_q.pop_front()));
            end
        end else begin
            check("r8_zero_when_idle", 260'(s8.r), 260'(0));
        end
    end

    always @(negedge clk) begin
        check("p_vld_coincident", 260'(p1.vld), 260'(p0.vld));
        if (p0.vld) begin
            if (expp0_q.size() > 0) check("p0_result", 260'(p0.r), 260'(expp0_q.pop_front()));
            if (expp1_q.size() > 0) check("p1_result", 260'(p1.r), 260'(expp1_q.pop_front()));
        end else begin
            check("p0_zero_when_idle", 260'(p0.r), 260'(0));
            check("p1_zero_when_idle", 260'(p1.r), 260'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                          input logic [7:0] exp, output int k);
        s8.a = a; s8.b = b; s8.m = m; s8.start = 1'b1;
        exp8_q.push_back(exp);
        @(negedge clk);
        k = cyc;
        s8.start = 1'b0;
        check("busy8_after_start", 260'(s8.busy), 260'(1));
    endtask

    task automatic wait8(input int k, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (scramble8) begin
                s8.a = 8'($urandom);
                s8.b = 8'($urandom);
            end
            @(negedge clk);
            if (s8.vld) seen = 1'b1;
        end
        check({name, "_vld_seen"}, 260'(seen), 260'(1));
        check({name, "_latency"}, 260'(cyc - k), 260'(W8 + 1));
        check({name, "_busy_low_at_vld"}, 260'(s8.busy), 260'(0));
        @(negedge clk);
        check({name, "_vld_one_wide"}, 260'(s8.vld), 260'(0));
    endtask

    task automatic run256(input logic [255:0] a0, input logic [255:0] b0,
                          input logic [255:0] a1, input logic [255:0] b1,
                          input logic [255:0] m);
        int  k;
        bit  seen;
        p0.a = a0; p0.b = b0; p0.m = m; p0.start = 1'b1;
        p1.a = a1; p1.b = b1; p1.m = m; p1.start = 1'b1;
        expp0_q.push_back(mont_ref(260'(a0), 260'(b0), 260'(m), W256)[255:0]);
        expp1_q.push_back(mont_ref(260'(a1), 260'(b1), 260'(m), W256)[255:0]);
        @(negedge clk);
        k = cyc;
        p0.start = 1'b0; p1.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (p0.vld) seen = 1'b1;
        end
        check("p_vld_seen", 260'(seen), 260'(1));
        check("p_latency", 260'(cyc - k), 260'(W256 + 1));
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_r;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int         k;
        int         n0;
        logic [7:0] m8, a8, b8;
        logic [255:0] m, a0, b0, a1, b1;

        tbl[0] = '{a: 8'd1,   b: 8'd1,   exp_r: 8'd225};
        tbl[1] = '{a: 8'd17,  b: 8'd17,  exp_r: 8'd17};
        tbl[2] = '{a: 8'd238, b: 8'd238, exp_r: 8'd225};
        tbl[3] = '{a: 8'd0,   b: 8'd200, exp_r: 8'd0};
        tbl[4] = '{a: 8'd2,   b: 8'd1,   exp_r: 8'd211};
        tbl[5] = '{a: 8'd1,   b: 8'd17,  exp_r: 8'd1};

        total = 0; bad = 0; vld8_cnt = 0; scramble8 = 1'b0;
        s8.a = '0; s8.b = '0; s8.m = '0; s8.start = 1'b0;
        p0.a = '0; p0.b = '0; p0.m = '0; p0.start = 1'b0;
        p1.a = '0; p1.b = '0; p1.m = '0; p1.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vld", 260'(s8.vld), 260'(0));
        check("reset_r", 260'(s8.r), 260'(0));
        check("reset_busy", 260'(s8.busy), 260'(0));
        check("reset_state", 260'(dbg8), 260'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors at m = 239
        for (int i = 0; i < 6; i++) begin
            start8(tbl[i].a, tbl[i].b, 8'd239, tbl[i].exp_r, k);
            wait8(k, "tbl");
        end

        // Random 8-bit vectors with random odd moduli
        for (int i = 0; i < 150; i++) begin
            m8 = 8'($urandom_range(127, 1) * 2 + 1);
            a8 = 8'($urandom_range(int'(m8) - 1, 0));
            b8 = 8'($urandom_range(int'(m8) - 1, 0));
            start8(a8, b8, m8, mont_ref(260'(a8), 260'(b8), 260'(m8), W8)[7:0], k);
            wait8(k, "rand8");
        end

        // Start pulses while busy are ignored
        n0 = vld8_cnt;
        s8.a = 8'd5; s8.b = 8'd9; s8.m = 8'd239; s8.start = 1'b1;
        exp8_q.push_back(mont_ref(260'(5), 260'(9), 260'(239), W8)[7:0]);
        @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            s8.start = (i == 3 || i == W8 - 1);
            if (s8.start) begin
                s8.a = 8'($urandom_range(238, 0));
                s8.b = 8'($urandom_range(238, 0));
            end
            @(negedge clk);
        end
        s8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_start_vld_count", 260'(vld8_cnt - n0), 260'(1));

        // Back-to-back: second start issued in the vld cycle
        start8(8'd17, 8'd17, 8'd239, 8'd17, k);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (s8.vld) seen = 1'b1;
            end
            check("b2b_first_vld_seen", 260'(seen), 260'(1));
            check("b2b_first_latency", 260'(cyc - k), 260'(W8 + 1));
        end
        start8(8'd238, 8'd238, 8'd239, 8'd225, k);
        wait8(k, "b2b_second");

        // Asynchronous reset during LOOP discards the operation
        start8(8'd100, 8'd77, 8'd239, 8'd0, k);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_vld", 260'(s8.vld), 260'(0));
        check("midreset_r", 260'(s8.r), 260'(0));
        check("midreset_busy", 260'(s8.busy), 260'(0));
        check("midreset_state", 260'(dbg8), 260'(0));
        exp8_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n0 = vld8_cnt;
        repeat (15) @(negedge clk);
        check("midreset_no_vld", 260'(vld8_cnt - n0), 260'(0));
        start8(8'd100, 8'd77, 8'd239, mont_ref(260'(100), 260'(77), 260'(239), W8)[7:0], k);
        wait8(k, "post_reset");

        // Operands changing after the start edge have no effect
        scramble8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom_range(238, 0));
            b8 = 8'($urandom_range(238, 0));
            start8(a8, b8, 8'd239, mont_ref(260'(a8), 260'(b8), 260'(239), W8)[7:0], k);
            wait8(k, "scramble");
        end
        scramble8 = 1'b0;

        // Paired 256-bit instances, alternating P-256 and random odd moduli
        for (int i = 0; i < 40; i++) begin
            m = (i % 2 == 0) ? P256 : (rand256() | 256'd1 | {1'b1, 255'd0});
            a0 = rand256() % m; b0 = rand256() % m;
            a1 = rand256() % m; b1 = rand256() % m;
            if (i == 1) begin
                a0 = m - 256'd1; b0 = m - 256'd1;
            end
            run256(a0, b0, a1, b1, m);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("exp8_q_drained", 260'(exp8_q.size()), 260'(0));
        check("expp0_q_drained", 260'(expp0_q.size()), 260'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
